// File: rtl/tt_pkg.sv
// Shared types and constants for the tt_sweep_checker exhaustive-test sequencer.
package tt_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam int unsigned NUM_MINTERMS = 16;
   localparam int unsigned MINTERM_W    = 4;

   // Sum of minterms 5, 6, 7, 8, 10 and 11.
   localparam logic [NUM_MINTERMS-1:0] TT_EXPECTED_DEFAULT = 16'h0DE0;

   function automatic logic [MINTERM_W-1:0] lowest_set(input logic [NUM_MINTERMS-1:0] v);
      logic [MINTERM_W-1:0] r;
      r = '0;
      for (int unsigned i = NUM_MINTERMS; i > 0; i--) begin
         if (v[i-1]) r = MINTERM_W'(i - 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Request/result bundle between a sweep requester (master) and tt_sweep_checker (slave).
// Mismatch-diagnostic signals exist only when TT_MISMATCH_EN is defined.
interface tt_sweep_checker_if;
   import tt_pkg::*;

   logic                    start;
   logic                    busy;
   logic                    done;
   logic [NUM_MINTERMS-1:0] tt;
   logic [MINTERM_W:0]      ones;
   logic                    pass;
`ifdef TT_MISMATCH_EN
   logic [NUM_MINTERMS-1:0] mismatch;
   logic [MINTERM_W-1:0]    first_fail;
   logic                    fail_valid;
`endif

   modport master (
      output start,
      input  busy, done, tt, ones, pass
`ifdef TT_MISMATCH_EN
      , input mismatch, first_fail, fail_valid
`endif
   );

   modport slave (
      input  start,
      output busy, done, tt, ones, pass
`ifdef TT_MISMATCH_EN
      , output mismatch, first_fail, fail_valid
`endif
   );

endinterface

// File: rtl/tt_minterm_ctr.sv
// Minterm index and settle counter: holds each minterm SETTLE_CYCLES+1 cycles and
// strobes on the last cycle of each period.
module tt_minterm_ctr import tt_pkg::*; #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 run,
   input  logic                 clr,
   output logic [MINTERM_W-1:0] idx,
   output logic                 sample_strobe,
   output logic                 last
);

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   logic [3:0] cnt;

   always_comb begin
      sample_strobe = run && (cnt == '0);
      last          = (idx == MINTERM_W'(NUM_MINTERMS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         cnt <= '0;
      end else if (load) begin
         idx <= '0;
         cnt <= SETTLE;
      end else if (clr) begin
         idx <= '0;
      end else if (run) begin
         if (cnt != '0) begin
            cnt <= cnt - 4'd1;
         end else if (!last) begin
            idx <= idx + MINTERM_W'(1);
            cnt <= SETTLE;
         end
      end
   end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive 16-minterm sweep of a 4-input FUT with truth-table capture and verdict.
// Define TT_MISMATCH_EN to add mismatch / first_fail / fail_valid diagnostics.
module tt_sweep_checker import tt_pkg::*; #(
   parameter int unsigned           SETTLE_CYCLES = 2,
   parameter logic [NUM_MINTERMS-1:0] EXPECTED    = TT_EXPECTED_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 f,
   output logic [MINTERM_W-1:0] abcd,
   tt_sweep_checker_if.slave    bus
);

   state_t                  state;
   logic                    load, run, clr;
   logic                    sample_strobe, last;
   logic [MINTERM_W-1:0]    idx;
   logic [NUM_MINTERMS-1:0] tt_next;

   always_comb begin
      load         = (state == IDLE) && bus.start;
      run          = (state == RUN);
      clr          = (state == FINISH);
      tt_next      = bus.tt;
      tt_next[idx] = f;
      abcd         = idx;
   end

   tt_minterm_ctr #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_ctr (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (load),
      .run           (run),
      .clr           (clr),
      .idx           (idx),
      .sample_strobe (sample_strobe),
      .last          (last)
   );

   // The verdict is taken from tt_next on the final sample so it is already valid
   // in the cycle done is high, rather than one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.tt     <= '0;
         bus.ones   <= '0;
         bus.pass   <= 1'b0;
`ifdef TT_MISMATCH_EN
         bus.mismatch   <= '0;
         bus.first_fail <= '0;
         bus.fail_valid <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  bus.tt   <= '0;
                  bus.ones <= '0;
                  bus.pass <= 1'b0;
`ifdef TT_MISMATCH_EN
                  bus.mismatch   <= '0;
                  bus.first_fail <= '0;
                  bus.fail_valid <= 1'b0;
`endif
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (sample_strobe) begin
                  bus.tt   <= tt_next;
                  bus.ones <= bus.ones + {{MINTERM_W{1'b0}}, f};
                  if (last) begin
                     bus.pass <= (tt_next == EXPECTED);
`ifdef TT_MISMATCH_EN
                     bus.mismatch   <= tt_next ^ EXPECTED;
                     bus.first_fail <= lowest_set(tt_next ^ EXPECTED);
                     bus.fail_valid <= |(tt_next ^ EXPECTED);
`endif
                     bus.done <= 1'b1;
                     state    <= FINISH;
                  end
               end
            end
            FINISH: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench for tt_sweep_checker: table vectors, random FUT masks against a
// truth-table model, and hand-written start-while-busy and mid-sweep reset sequences.
module tb_tt_sweep_checker;

   localparam logic [15:0] EXP = 16'h0DE0;
   localparam int unsigned SETTLE0 = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_req = 1'b0;
   logic        sel = 1'b0;
   logic [15:0] fmask = 16'h0000;
   logic        f0, f1;
   logic [3:0]  abcd0, abcd1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tt_sweep_checker_if bus0 ();
   tt_sweep_checker_if bus1 ();

   assign bus0.start = start_req & ~sel;
   assign bus1.start = start_req & sel;
   assign f0 = fmask[abcd0];
   assign f1 = fmask[abcd1];

   tt_sweep_checker #(.SETTLE_CYCLES(SETTLE0), .EXPECTED(EXP)) dut0 (
      .clk (clk), .rst_n (rst_n), .f (f0), .abcd (abcd0), .bus (bus0.slave));
   tt_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(EXP)) dut1 (
      .clk (clk), .rst_n (rst_n), .f (f1), .abcd (abcd1), .bus (bus1.slave));

   logic [3:0]  s_abcd;
   logic        s_busy, s_done, s_pass;
   logic [15:0] s_tt;
   logic [4:0]  s_ones;
`ifdef TT_MISMATCH_EN
   logic [15:0] s_mm;
   logic [3:0]  s_ff;
   logic        s_fv;
`endif

   always_comb begin
      s_abcd = sel ? abcd1     : abcd0;
      s_busy = sel ? bus1.busy : bus0.busy;
      s_done = sel ? bus1.done : bus0.done;
      s_pass = sel ? bus1.pass : bus0.pass;
      s_tt   = sel ? bus1.tt   : bus0.tt;
      s_ones = sel ? bus1.ones : bus0.ones;
`ifdef TT_MISMATCH_EN
      s_mm = sel ? bus1.mismatch   : bus0.mismatch;
      s_ff = sel ? bus1.first_fail : bus0.first_fail;
      s_fv = sel ? bus1.fail_valid : bus0.fail_valid;
`endif
   end

   typedef struct {
      logic        sel;
      logic [15:0] mask;
      bit          extra;
      logic [15:0] e_tt;
      logic [4:0]  e_ones;
      logic        e_pass;
      logic [15:0] e_mm;
      logic [3:0]  e_ff;
      logic        e_fv;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: derived from the FUT mask alone.
   function automatic int unsigned model_ones(input logic [15:0] m);
      int unsigned n = 0;
      for (int unsigned i = 0; i < 16; i++) n += m[i] ? 1 : 0;
      return n;
   endfunction

   function automatic logic [3:0] model_first(input logic [15:0] m);
      for (int unsigned i = 0; i < 16; i++) if (m[i]) return 4'(i);
      return 4'd0;
   endfunction

   task automatic sweep(input vec_t v);
      int unsigned p, last_c;
      int done_cnt = 0, done_at = -1, abcd_err = 0, busy_err = 0;
      p = v.sel ? 1 : SETTLE0 + 1;
      last_c = 16 * p;
      sel = v.sel;
      fmask = v.mask;
      @(negedge clk) start_req = 1'b1;
      @(negedge clk) start_req = 1'b0;
      for (int unsigned c = 0; c <= last_c + 2; c++) begin
         if (c < last_c && s_abcd !== 4'(c / p)) abcd_err++;
         if (s_busy !== (c <= last_c)) busy_err++;
         if (s_done === 1'b1) begin
            done_cnt++;
            done_at = int'(c);
         end
         if (c == last_c) begin
            chk("tt", 32'(s_tt), 32'(v.e_tt));
            chk("ones", 32'(s_ones), 32'(v.e_ones));
            chk("pass", 32'(s_pass), 32'(v.e_pass));
`ifdef TT_MISMATCH_EN
            chk("mismatch", 32'(s_mm), 32'(v.e_mm));
            chk("first_fail", 32'(s_ff), 32'(v.e_ff));
            chk("fail_valid", 32'(s_fv), 32'(v.e_fv));
`endif
         end
         start_req = v.extra && (c == 10 || c == last_c);
         @(negedge clk);
      end
      start_req = 1'b0;
      chk("abcd_seq_errors", 32'(abcd_err), 32'd0);
      chk("busy_errors", 32'(busy_err), 32'd0);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_at), 32'(last_c));
      chk("tt_held", 32'(s_tt), 32'(v.e_tt));
      chk("idle_after", 32'(s_busy), 32'd0);
   endtask

   initial begin
      vec_t rv;
      int unsigned wait_n;
      int bad;

      vecs[0] = '{1'b0, EXP,      1'b0, 16'h0DE0, 5'd6,  1'b1, 16'h0000, 4'd0, 1'b0};
      vecs[1] = '{1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 5'd16, 1'b0, 16'hF21F, 4'd0, 1'b1};
      vecs[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0,  1'b0, 16'h0DE0, 4'd5, 1'b1};
      vecs[3] = '{1'b1, EXP,      1'b0, 16'h0DE0, 5'd6,  1'b1, 16'h0000, 4'd0, 1'b0};
      vecs[4] = '{1'b0, EXP,      1'b1, 16'h0DE0, 5'd6,  1'b1, 16'h0000, 4'd0, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_abcd", 32'(abcd0), 32'd0);
      chk("rst_busy", 32'(bus0.busy), 32'd0);
      chk("rst_done", 32'(bus0.done), 32'd0);
      chk("rst_tt", 32'(bus0.tt), 32'd0);
      chk("rst_ones", 32'(bus0.ones), 32'd0);
      chk("rst_pass", 32'(bus0.pass), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) sweep(vecs[i]);

      for (int i = 0; i < 6; i++) begin
         rv.sel   = 1'($urandom_range(0, 1));
         rv.mask  = 16'($urandom);
         if (i == 0) rv.mask = EXP ^ 16'h8000;
         rv.extra = 1'b0;
         rv.e_tt  = rv.mask;
         rv.e_ones = 5'(model_ones(rv.mask));
         rv.e_pass = (rv.mask == EXP);
         rv.e_mm  = rv.mask ^ EXP;
         rv.e_ff  = model_first(rv.mask ^ EXP);
         rv.e_fv  = (rv.mask != EXP);
         sweep(rv);
      end

      // Reset in the middle of a sweep.
      sel = 1'b0;
      fmask = EXP;
      @(negedge clk) start_req = 1'b1;
      @(negedge clk) start_req = 1'b0;
      wait_n = 0;
      while (abcd0 !== 4'd7 && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      chk("reach_abcd7_timeout", 32'(wait_n < 100), 32'd1);
      chk("tt_partial_before_rst", 32'(bus0.tt), 32'h0060);
      rst_n = 1'b0;
      #1;
      chk("midrst_abcd", 32'(abcd0), 32'd0);
      chk("midrst_busy", 32'(bus0.busy), 32'd0);
      chk("midrst_tt", 32'(bus0.tt), 32'd0);
      chk("midrst_ones", 32'(bus0.ones), 32'd0);
      chk("midrst_done", 32'(bus0.done), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) bad++;
      end
      chk("no_activity_after_rst", 32'(bad), 32'd0);
      sweep(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
